// File: rtl/aud_sample_fifo_if.sv
// Producer/consumer handshake bundle for the audio sample FIFO.
// The FIFO takes the slave side; whoever drives samples in and pulls them out is master.
interface aud_sample_fifo_if #(
  parameter int DATA_W = 16
);
  logic                     wr_valid;
  logic signed [DATA_W-1:0] wr_data;
  logic                     wr_ready;
  logic                     rd_valid;
  logic signed [DATA_W-1:0] rd_data;
  logic                     rd_ready;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/aud_sample_fifo.sv
// Single-clock first-word-fall-through sample FIFO between recorder and DSP,
// with sticky overflow/underrun flags and saturating event counters.
module aud_sample_fifo #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 16,
  parameter int DROP_OLDEST = 0,
  parameter int CNT_W       = 8,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  aud_sample_fifo_if.slave         bus,
  output logic signed [DATA_W-1:0] o_last_sample,
  output logic [ADDR_W:0]          o_level,
  output logic                     o_primed,
  output logic                     o_overflow,
  output logic                     o_underrun,
  output logic [CNT_W-1:0]         o_ovf_cnt,
  output logic [CNT_W-1:0]         o_udr_cnt
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic            DROP     = (DROP_OLDEST != 0);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                   state, state_nxt;
  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]        wr_ptr, rd_ptr;
  logic                     flush, full, empty;
  logic                     wr_fire, rd_fire, drop, ovf_evt, udr_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign flush = i_rst | i_clear;
  assign full  = (o_level == FULL_LVL);
  assign empty = (o_level == '0);

  assign bus.wr_ready = ~full | DROP;
  assign bus.rd_valid = ~empty;
  assign bus.rd_data  = empty ? '0 : mem[rd_ptr];

  assign wr_fire = bus.wr_valid & bus.wr_ready;
  assign rd_fire = bus.rd_valid & bus.rd_ready;
  // Only reachable with DROP set: a full FIFO otherwise refuses the write.
  assign drop    = full & wr_fire & ~rd_fire;
  // Without DROP a full-FIFO write is lost even if a pop frees a slot this cycle.
  assign ovf_evt = full & bus.wr_valid & (~DROP | ~rd_fire);
  assign udr_evt = (state == RUN) & empty & bus.rd_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_primed  = (state == RUN);
    case (state)
      IDLE:    if (wr_fire) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_fire && !flush) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_level       <= '0;
      o_last_sample <= '0;
      o_overflow    <= 1'b0;
      o_underrun    <= 1'b0;
      o_ovf_cnt     <= '0;
      o_udr_cnt     <= '0;
    end else begin
      if (wr_fire)          wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire || drop)  rd_ptr <= rd_ptr + 1'b1;
      if (rd_fire)          o_last_sample <= bus.rd_data;

      if (wr_fire && !rd_fire && !drop) o_level <= o_level + 1'b1;
      else if (rd_fire && !wr_fire)     o_level <= o_level - 1'b1;

      if (ovf_evt) begin
        o_overflow <= 1'b1;
        o_ovf_cnt  <= sat_inc(o_ovf_cnt);
      end
      if (udr_evt) begin
        o_underrun <= 1'b1;
        o_udr_cnt  <= sat_inc(o_udr_cnt);
      end
    end
  end

endmodule
